// File: rtl/square_edge_gen.sv
// rtl/square_edge_gen.sv - square outline / fill-span generator with screen clipping
module square_edge_gen #(
    parameter int XW = 7,
    parameter int YW = 6,
    parameter int CW = 9,
    parameter int DW = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] xcenter,
    input  logic [CW-1:0] ycenter,
    input  logic [DW-1:0] depth,
    input  logic          fill,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] xstart,
    output logic [XW-1:0] xend,
    output logic [YW-1:0] ystart,
    output logic [YW-1:0] yend,
    output logic [1:0]    etype,
    output logic          done
);
    localparam int BW = CW + 2;
    localparam logic signed [BW-1:0] XMAX_S = BW'((1 << XW) - 1);
    localparam logic signed [BW-1:0] YMAX_S = BW'((1 << YW) - 1);
    localparam logic signed [BW-1:0] ONE    = BW'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] xc_q, yc_q;
    logic [DW-1:0] d_q;
    logic          fill_q;
    logic [1:0]    edge_idx, sel_idx;
    logic [YW-1:0] row;

    logic signed [BW-1:0] dd, xcs, ycs, xs, xe, ys, ye;
    logic signed [BW-1:0] ia, ib, ic, id;
    logic [1:0]    it;
    logic          item_ok, span_empty, handshake, edge_adv, last_row;
    logic [XW-1:0] cx0, cx1, ea, eb;
    logic [YW-1:0] cy0, cy1, ec, ed;

    function automatic logic [XW-1:0] clip_x(input logic signed [BW-1:0] v);
        if (v[BW-1]) return '0;
        if (v > XMAX_S) return '1;
        return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clip_y(input logic signed [BW-1:0] v);
        if (v[BW-1]) return '0;
        if (v > YMAX_S) return '1;
        return v[YW-1:0];
    endfunction

    // Latched inputs are stable for the whole job, so the raw bounds settle during CALC.
    assign dd  = BW'(d_q);
    assign xcs = BW'(xc_q);
    assign ycs = BW'(yc_q);
    assign xs  = xcs - dd;
    assign ys  = ycs - dd;
    assign xe  = (d_q == '0) ? xcs : xcs + dd - ONE;
    assign ye  = (d_q == '0) ? ycs : ycs + dd - ONE;

    assign cx0 = clip_x(xs);
    assign cx1 = clip_x(xe);
    assign cy0 = clip_y(ys);
    assign cy1 = clip_y(ye);
    assign span_empty = xe[BW-1] || (xs > XMAX_S) || ye[BW-1] || (ys > YMAX_S);

    // Edge about to be loaded: edge 0 from CALC, otherwise the one after edge_idx.
    always_comb begin
        sel_idx = (state == S_CALC) ? 2'd0 : edge_idx + 2'd1;
        ia = xs;
        ib = xe;
        ic = ys;
        id = ye;
        it = 2'b10;
        case (sel_idx)
            2'd0:    begin ib = xs; it = 2'b01; end
            2'd1:    begin ia = xe; it = 2'b01; end
            2'd2:    id = ys;
            default: ic = ye;
        endcase
        item_ok = !(ib[BW-1] || (ia > XMAX_S) || id[BW-1] || (ic > YMAX_S));
        ea = clip_x(ia);
        eb = clip_x(ib);
        ec = clip_y(ic);
        ed = clip_y(id);
    end

    assign handshake = out_valid & out_ready;
    assign edge_adv  = ~out_valid | out_ready;
    assign last_row  = (row == cy1);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: state_nxt = (fill_q && span_empty) ? S_DONE : S_EMIT;
            S_EMIT: begin
                if (fill_q) begin
                    if (handshake && last_row) state_nxt = S_DONE;
                end else if (edge_adv && edge_idx == 2'd3) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xc_q      <= '0;
            yc_q      <= '0;
            d_q       <= '0;
            fill_q    <= 1'b0;
            edge_idx  <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            xstart    <= '0;
            xend      <= '0;
            ystart    <= '0;
            yend      <= '0;
            etype     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    xc_q   <= xcenter;
                    yc_q   <= ycenter;
                    d_q    <= ~depth;  // DMAX - depth
                    fill_q <= fill;
                end
                S_CALC: begin
                    edge_idx <= '0;
                    row      <= cy0;
                    if (fill_q) begin
                        out_valid <= ~span_empty;
                        xstart    <= cx0;
                        xend      <= cx1;
                        ystart    <= cy0;
                        yend      <= cy0;
                        etype     <= 2'b10;
                    end else begin
                        out_valid <= item_ok;
                        xstart    <= ea;
                        xend      <= eb;
                        ystart    <= ec;
                        yend      <= ed;
                        etype     <= it;
                    end
                end
                S_EMIT: begin
                    if (fill_q) begin
                        if (handshake) begin
                            if (last_row) begin
                                out_valid <= 1'b0;
                            end else begin
                                row    <= row + 1'b1;
                                ystart <= row + 1'b1;
                                yend   <= row + 1'b1;
                            end
                        end
                    end else if (edge_adv) begin
                        if (edge_idx == 2'd3) begin
                            out_valid <= 1'b0;
                        end else begin
                            edge_idx  <= edge_idx + 2'd1;
                            out_valid <= item_ok;
                            xstart    <= ea;
                            xend      <= eb;
                            ystart    <= ec;
                            yend      <= ed;
                            etype     <= it;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/square_edge_gen.md
# square_edge_gen

Parametrised square-outline and square-fill span generator for the 3D renderer's raster stage. It accepts one square per start command: a center point and a depth. The half-size is derived from depth, and the square is clipped to a configurable screen size. It then streams clipped edges (outline mode) or one horizontal span per row (fill mode) to the line drawer over a valid/ready handshake. Edges or rows that fall entirely off screen are suppressed rather than flagged.

## Interface
- XW, 7: screen x coordinate width; XMAX = 2^XW-1
- YW, 6: screen y coordinate width; YMAX = 2^YW-1
- CW, 9: center coordinate width (unsigned); internal raw bounds are CW+2 bits signed
- DW, 6: depth width; DMAX = 2^DW-1
- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- xcenter  in  CW  square center x, sampled on accept
- ycenter  in  CW  square center y, sampled on accept
- depth  in  DW  depth, sampled on accept; D = DMAX-depth
- fill  in  1  mode, sampled on accept: 0 outline, 1 filled spans
- busy  out  1  high from cycle after accept through the done cycle
- out_valid  out  1  output item valid
- out_ready  in  1  downstream accepts item when out_valid&out_ready
- xstart, xend  out  XW  clipped x range of item
- ystart, yend  out  YW  clipped y range of item
- etype  out  2  01 vertical edge, 10 horizontal edge/span
- done  out  1  one-cycle pulse: square finished

## Operation
- Raw bounds, signed CW+2: xs=xc-D; xe = xc if D=0 else xc+D-1; same for ys/ye with yc.
- Clip: value<0 → 0; value>max → max (XMAX or YMAX).
- Per item, x range [a,b] and y range [c,d] in raw form. The item is invalid if b<0, a>XMAX, d<0 or c>YMAX. An invalid item is never emitted.
- Outline order: LEFT (xs,xs,ys,ye,01), RIGHT (xe,xe,ys,ye,01), TOP (xs,xe,ys,ys,10), BOTTOM (xs,xe,ye,ye,10).
- Fill: rows r from clip(ys) to clip(ye) inclusive. Each row emits (clip xs, clip xe, r, r, 10). If the x range or the y range is invalid, zero rows are emitted.
- D=0: single-point square; outline still emits 4 identical point items.
- States:
  - IDLE: start → CALC, latching inputs.
  - CALC: registers raw bounds → EMIT.
  - EMIT: walks the 4-edge index or the row counter.
  - DONE: one cycle → IDLE.
- In EMIT, a valid item drives out_valid until handshake, then advances. An invalid outline edge consumes one cycle with out_valid=0 and advances. Fill with an empty range goes CALC→DONE directly.
- Advancing past the last item → DONE. The done pulse occurs in the DONE cycle.
- start while busy: ignored, no queuing.
- Reset (any time, mid-stream included): state IDLE. busy, out_valid, done, xstart, xend, ystart, yend and etype all 0 immediately.

## Timing
- Accept at cycle 0 (start=1, busy=0). CALC at cycle 1. The first EMIT cycle is cycle 2, with out_valid registered.
- Output data and etype are registered and held stable while out_valid&~out_ready.
- With out_ready tied high, throughput is one item per cycle. Suppressed edges each cost one idle cycle.
- busy=1 from cycle 1 to the DONE cycle inclusive. A new start is accepted in the cycle after DONE.
- Outline, all valid, out_ready=1: items in cycles 2–5, done in cycle 6.

## Test plan
- Outline: xc=64, yc=32, depth=59 (D=4) → (60,60,28,35,01), (67,67,28,35,01), (60,67,28,28,10), (60,67,35,35,10); done at cycle 6.
- Clipping: xc=2, yc=62, depth=53 (D=10) → LEFT suppressed (x=-8) and BOTTOM suppressed (y=71). Emits (11,11,52,63,01) then (0,11,52,52,10); done once.
- Fill: xc=10, yc=5, depth=61 (D=2), fill=1 → four spans (8,11,r,r,10) for r=3,4,5,6 in order; then done.
- Backpressure: outline case with out_ready low for 5 cycles at the first item → outputs unchanged and no advance. Extra start pulses are ignored, and there is still exactly one done.
- Off screen: xc=200, yc=10, depth=60 (D=3) → zero valid items. Outline gives done at cycle 6. The same input with fill=1 gives done at cycle 2.
- Reset: drop reset_n while out_valid=1 → all outputs 0 asynchronously. After release, a new start for the first case reproduces the full sequence.
